// File: rtl/common_types.sv
// rtl/common_types.sv - shared types for the dyt memory controller
// Contents: word_t bus word, memctrl_state_t FSM states, grant_t requester id,
// CNT_W latency counter width (READ_LATENCY up to 4 must fit).
package common_types;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } memctrl_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam int CNT_W = 3;

endpackage

// File: rtl/dyt_mem_ctrl_if.sv
// rtl/dyt_mem_ctrl_if.sv - cpu-side request/response bundle for dyt_mem_ctrl
// Instruction port: iren, iaddr -> ihit, iload.
// Data port: dren, dwen, daddr, dstore -> dhit, dload.
// master: the requesting cpu side; slave: the memory controller.
interface dyt_mem_ctrl_if;
  import common_types::*;

  logic  iren;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  logic  dren;
  logic  dwen;
  word_t daddr;
  word_t dstore;
  logic  dhit;
  word_t dload;

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore,
    input  ihit, iload, dhit, dload
  );

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore,
    output ihit, iload, dhit, dload
  );

endinterface

// File: rtl/dyt_mem_rr_arb.sv
// rtl/dyt_mem_rr_arb.sv - instruction/data grant selection with anti-starvation
// Ports: CLK, nRST; iren, dreq (dren|dwen) requests; take (grant accepted this
// cycle); grant_sel (combinational choice); grant (owner of the current transaction).
module dyt_mem_rr_arb
  import common_types::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   iren,
  input  logic   dreq,
  input  logic   take,
  output grant_t grant_sel,
  output grant_t grant
);

  grant_t last_grant;

  // Data normally wins; after a data grant a waiting fetch goes first.
  always_comb begin
    grant_sel = GRANT_I;
    if (dreq && !(last_grant == GRANT_D && iren)) begin
      grant_sel = GRANT_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_grant <= GRANT_I;
    end else if (take) begin
      last_grant <= grant_sel;
    end
  end

  // The last grant is held for the whole transaction, so it doubles as the
  // owner of the access in flight.
  assign grant = last_grant;

endmodule

// File: rtl/dyt_mem_ctrl.sv
// rtl/dyt_mem_ctrl.sv - single-outstanding SRAM controller for fetch and data ports
// Ports: CLK, nRST (sync active-low); cpu (dyt_mem_ctrl_if.slave);
// sram_address, sram_w_data, sram_ren, sram_wen out; sram_r_data in.
module dyt_mem_ctrl
  import common_types::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic          CLK,
  input  logic          nRST,
  dyt_mem_ctrl_if.slave cpu,
  output word_t         sram_address,
  output word_t         sram_w_data,
  output logic          sram_ren,
  output logic          sram_wen,
  input  word_t         sram_r_data
);

  memctrl_state_t   state;
  memctrl_state_t   state_nxt;
  grant_t           grant_sel;
  grant_t           grant;
  logic             dreq;
  logic             any_req;
  logic             take;
  logic             cap;
  logic             wr_r;
  word_t            addr_r;
  word_t            data_r;
  logic [CNT_W-1:0] cnt;
  word_t            iload_r;
  word_t            dload_r;

  assign dreq    = cpu.dren | cpu.dwen;
  assign any_req = dreq | cpu.iren;
  assign take    = (state == IDLE) && any_req;
  // cnt is 1 in the first WAIT cycle, so it equals the cycles since ACCESS.
  assign cap     = (state == WAIT) && (cnt == CNT_W'(READ_LATENCY));

  dyt_mem_rr_arb u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .iren      (cpu.iren),
    .dreq      (dreq),
    .take      (take),
    .grant_sel (grant_sel),
    .grant     (grant)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated by nRST so strobes drop in the reset cycle itself.
  always_comb begin
    state_nxt    = state;
    sram_address = '0;
    sram_w_data  = '0;
    sram_ren     = 1'b0;
    sram_wen     = 1'b0;
    cpu.ihit     = 1'b0;
    cpu.dhit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt    = wr_r ? RESP : WAIT;
        sram_address = addr_r;
        sram_ren     = nRST & ~wr_r;
        sram_wen     = nRST & wr_r;
        if (wr_r) sram_w_data = data_r;
      end
      WAIT: begin
        if (cap) state_nxt = RESP;
        sram_address = addr_r;
      end
      RESP: begin
        state_nxt = IDLE;
        cpu.ihit  = nRST && (grant == GRANT_I);
        cpu.dhit  = nRST && (grant == GRANT_D);
      end
      default: state_nxt = IDLE;
    endcase
    if (!nRST) begin
      sram_address = '0;
      sram_w_data  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_r    <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      cnt     <= '0;
      iload_r <= '0;
      dload_r <= '0;
    end else begin
      if (take) begin
        if (grant_sel == GRANT_D) begin
          wr_r   <= cpu.dwen;
          addr_r <= cpu.daddr;
          data_r <= cpu.dstore;
        end else begin
          wr_r   <= 1'b0;
          addr_r <= cpu.iaddr;
          data_r <= '0;
        end
      end
      if (state == ACCESS) begin
        cnt <= CNT_W'(1);
      end else if ((state == WAIT) && !cap) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cap) begin
        if (grant == GRANT_I) iload_r <= sram_r_data;
        else                  dload_r <= sram_r_data;
      end
    end
  end

  assign cpu.iload = iload_r;
  assign cpu.dload = dload_r;

endmodule

// File: tb/tb_dyt_mem_ctrl.sv
// tb/tb_dyt_mem_ctrl.sv - scoreboard bench for dyt_mem_ctrl at latency 1 and 3
module tb_dyt_mem_ctrl;
  import common_types::*;

  typedef struct packed {
    logic  wr;
    word_t data;
  } dexp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dyt_mem_ctrl_if bus ();
  dyt_mem_ctrl_if bus3 ();

  word_t s_addr, s_wdata, s_rdata;
  logic  s_ren, s_wen;
  word_t t_addr, t_wdata, t_rdata;
  logic  t_ren, t_wen;

  dyt_mem_ctrl #(.READ_LATENCY(1)) dut (
    .CLK          (clk),
    .nRST         (nrst),
    .cpu          (bus),
    .sram_address (s_addr),
    .sram_w_data  (s_wdata),
    .sram_ren     (s_ren),
    .sram_wen     (s_wen),
    .sram_r_data  (s_rdata)
  );

  dyt_mem_ctrl #(.READ_LATENCY(3)) dut3 (
    .CLK          (clk),
    .nRST         (nrst),
    .cpu          (bus3),
    .sram_address (t_addr),
    .sram_w_data  (t_wdata),
    .sram_ren     (t_ren),
    .sram_wen     (t_wen),
    .sram_r_data  (t_rdata)
  );

  int    checks = 0;
  int    errors = 0;
  word_t iq[$];
  dexp_t dq[$];
  bit    hist[$];
  word_t last_iload = '0;
  word_t last_dload = '0;
  word_t ref_mem[word_t];
  word_t mem1[word_t];
  word_t mem3[word_t];
  word_t pipe3[3];

  logic [7:0] w_ren, w_wen, w_ihit, w_dhit;
  word_t      w_addr[8];
  word_t      w_wdata[8];
  word_t      w_load[8];

  function automatic word_t init_val(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic word_t ref_rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic void check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // SRAM models: data appears READ_LATENCY edges after the ren cycle, junk otherwise.
  always @(posedge clk) begin
    if (s_wen) mem1[s_addr] = s_wdata;
    s_rdata <= s_ren ? (mem1.exists(s_addr) ? mem1[s_addr] : init_val(s_addr)) : $urandom();
  end

  always @(posedge clk) begin
    if (t_wen) mem3[t_addr] = t_wdata;
    pipe3[0] <= t_ren ? (mem3.exists(t_addr) ? mem3[t_addr] : init_val(t_addr)) : $urandom();
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign t_rdata = pipe3[2];

  // Monitor: pops the expected response whenever the latency-1 DUT hits.
  always @(negedge clk) begin
    if (!nrst) begin
      last_iload = '0;
      last_dload = '0;
      check("rst_strobes", {28'b0, bus.ihit, bus.dhit, s_ren, s_wen}, '0);
      check("rst_addr", s_addr, '0);
      check("rst_wdata", s_wdata, '0);
    end else begin
      check("hit_exclusive", 32'(bus.ihit & bus.dhit), '0);
      if (!s_wen) check("wdata_zero_without_wen", s_wdata, '0);
      if (bus.ihit) begin
        hist.push_back(1'b0);
        checks++;
        if (iq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ihit: iload %h with no fetch outstanding", bus.iload);
        end else begin
          last_iload = iq.pop_front();
          check("iload", bus.iload, last_iload);
        end
        check("dload_hold_on_ihit", bus.dload, last_dload);
      end
      if (bus.dhit) begin
        dexp_t e;
        hist.push_back(1'b1);
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dhit: dload %h with no data access outstanding", bus.dload);
        end else begin
          e = dq.pop_front();
          if (!e.wr) last_dload = e.data;
          check("dload", bus.dload, last_dload);
        end
        check("iload_hold_on_dhit", bus.iload, last_iload);
      end
    end
  end

  task automatic wait_hit(input bit sel, input bit is_d);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = sel ? bus3.dhit : (is_d ? bus.dhit : bus.ihit);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL hit_timeout: no hit within 60 cycles (sel %0d data %0d)", sel, is_d);
    end
  endtask

  // Called at posedge+1; holds the request until the hit, then drops it.
  task automatic do_fetch(input word_t a);
    bus.iren  = 1'b1;
    bus.iaddr = a;
    iq.push_back(ref_rd(a));
    wait_hit(1'b0, 1'b0);
    @(posedge clk); #1;
    bus.iren = 1'b0;
  endtask

  task automatic do_data(input bit rd, input bit wr, input word_t a, input word_t d);
    bus.dren   = rd;
    bus.dwen   = wr;
    bus.daddr  = a;
    bus.dstore = d;
    if (wr) begin
      ref_mem[a] = d;
      dq.push_back('{wr: 1'b1, data: '0});
    end else begin
      dq.push_back('{wr: 1'b0, data: ref_rd(a)});
    end
    wait_hit(1'b0, 1'b1);
    @(posedge clk); #1;
    bus.dren = 1'b0;
    bus.dwen = 1'b0;
  endtask

  task automatic do3(input bit rd, input bit wr, input word_t a, input word_t d);
    bus3.dren   = rd;
    bus3.dwen   = wr;
    bus3.daddr  = a;
    bus3.dstore = d;
    wait_hit(1'b1, 1'b1);
    @(posedge clk); #1;
    bus3.dren = 1'b0;
    bus3.dwen = 1'b0;
  endtask

  task automatic sample_win(input bit sel);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      w_ren[c]   = sel ? t_ren : s_ren;
      w_wen[c]   = sel ? t_wen : s_wen;
      w_ihit[c]  = sel ? bus3.ihit : bus.ihit;
      w_dhit[c]  = sel ? bus3.dhit : bus.dhit;
      w_addr[c]  = sel ? t_addr : s_addr;
      w_wdata[c] = sel ? t_wdata : s_wdata;
      w_load[c]  = sel ? bus3.dload : bus.dload;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iren = 1'b0;  bus.iaddr = '0; bus.dren = 1'b0; bus.dwen = 1'b0;
    bus.daddr = '0;   bus.dstore = '0;
    bus3.iren = 1'b0; bus3.iaddr = '0; bus3.dren = 1'b0; bus3.dwen = 1'b0;
    bus3.daddr = '0;  bus3.dstore = '0;
    mem1[32'h100]    = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iload", bus.iload, '0);
    check("rst_dload", bus.dload, '0);
    check("rst3_dload", bus3.dload, '0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Fetch of 0x100: ren pulse at t+1, ihit with DEADBEEF at t+3.
    @(posedge clk); #1;
    fork
      do_fetch(32'h100);
      sample_win(1'b0);
    join
    check("fetch_ren_pulse", 32'(w_ren[5:0]), 32'b000010);
    check("fetch_addr_access", w_addr[1], 32'h100);
    check("fetch_addr_wait", w_addr[2], 32'h100);
    check("fetch_ihit_t3", 32'(w_ihit[5:0]), 32'b001000);

    // Write 0x12345678 to 0x200: wen at t+1, dhit at t+2.
    @(posedge clk); #1;
    fork
      do_data(1'b0, 1'b1, 32'h200, 32'h1234_5678);
      sample_win(1'b0);
    join
    check("write_wen_pulse", 32'(w_wen[5:0]), 32'b000010);
    check("write_ren_none", 32'(w_ren[5:0]), '0);
    check("write_addr", w_addr[1], 32'h200);
    check("write_data", w_wdata[1], 32'h1234_5678);
    check("write_dhit_t2", 32'(w_dhit[5:0]), 32'b000100);
    check("write_no_ihit", 32'(w_ihit), '0);

    // Reset while a fetch sits in WAIT: abandoned, no hit, then a clean fetch.
    @(posedge clk); #1;
    bus.iren  = 1'b1;
    bus.iaddr = 32'h1040;
    @(negedge clk);
    @(negedge clk);
    check("rst_probe_access", 32'(s_ren), 32'd1);
    @(posedge clk); #1;
    nrst     = 1'b0;
    bus.iren = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_quiet", {28'b0, bus.ihit, bus.dhit, s_ren, s_wen}, '0);
      check("post_rst_addr", s_addr, '0);
    end
    check("post_rst_iload", bus.iload, '0);
    check("post_rst_dload", bus.dload, '0);
    @(posedge clk); #1;
    fork
      do_fetch(32'h1044);
      sample_win(1'b0);
    join
    check("post_rst_ihit_t3", 32'(w_ihit[5:0]), 32'b001000);

    // Both ports held with last grant = instruction: D, I, D.
    @(posedge clk); #1;
    hist.delete();
    fork
      begin
        do_data(1'b1, 1'b0, 32'h2000, '0);
        do_data(1'b1, 1'b0, 32'h2004, '0);
      end
      do_fetch(32'h1008);
    join
    check("alt_count", 32'(hist.size()), 32'd3);
    if (hist.size() == 3) check("alt_order", {29'b0, hist[0], hist[1], hist[2]}, 32'b101);

    // Randomized traffic on both ports at once.
    fork
      for (int k = 0; k < 30; k++) begin
        int g = $urandom_range(0, 3);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
        do_fetch(word_t'(32'h1000 + 4 * $urandom_range(0, 63)));
      end
      for (int k = 0; k < 40; k++) begin
        int g  = $urandom_range(0, 3);
        int op = $urandom_range(0, 9);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
        do_data(op < 4 || op >= 8, op >= 4, word_t'(32'h2000 + 4 * $urandom_range(0, 15)),
                word_t'($urandom()));
      end
    join
    repeat (4) @(negedge clk);
    check("iq_drained", 32'(iq.size()), '0);
    check("dq_drained", 32'(dq.size()), '0);

    // READ_LATENCY=3: dhit at t+5, address stable t+1..t+4.
    @(posedge clk); #1;
    do3(1'b0, 1'b1, 32'h300, 32'hCAFE_0303);
    fork
      do3(1'b1, 1'b0, 32'h300, '0);
      sample_win(1'b1);
    join
    check("l3_ren_pulse", 32'(w_ren[6:0]), 32'b0000010);
    for (int c = 1; c <= 4; c++) check("l3_addr_stable", w_addr[c], 32'h300);
    check("l3_dhit_t5", 32'(w_dhit[6:0]), 32'b0100000);
    check("l3_dload_before", w_load[4], '0);
    check("l3_dload", w_load[5], 32'hCAFE_0303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
